gf_div_seq: RTL
===============

// Module: gf_div_seq
// PURPOSE
//  Handshaked, multi-cycle GF(2^M) divider y = a / b for the Reed-Solomon datapath.
//  Generalises the 8-bit, LUT-based combinational divider:
//   - field width and primitive polynomial are parameters;
//   - no log/exp tables;
//   - valid/ready flow control and an explicit divide-by-zero flag.
//  Computes a * b^(2^M-2) (Fermat inverse) by iterative square-and-multiply,
//  one step per clock, then holds the result until the consumer accepts it.
// PARAMETERS
//  M     8       field width in bits; legal range 2..16
//  POLY  9'h11D  primitive polynomial, M+1 bits, bit M set (default x^8+x^4+x^3+x^2+1)
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  reset, asynchronous, active-high
//  in_valid     in   1  operand pair valid
//  in_ready     out  1  block can accept an operand pair
//  a            in   M  dividend
//  b            in   M  divisor
//  out_valid    out  1  result valid
//  out_ready    in   1  consumer accepts result
//  y            out  M  quotient a/b
//  div_by_zero  out  1  qualifies y: 1 when the divisor was 0
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, div_by_zero=0, internal regs=0.
//  Reset is asynchronous: asserting it mid-operation discards the operation immediately.
//  GF multiply: combinational function gfmul(x,y).
//   - carry-less product of two M-bit values, reduced modulo POLY;
//   - result is exactly M bits;
//   - instantiated twice: one squarer, one multiplier.
//  FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE:
//   - in_valid&in_ready at an edge latches acc<=a, sq<=b, dz<=(b==0), cnt<=M-1;
//   - then goes to CALC.
//  CALC, one step per cycle:
//   - sq_n = gfmul(sq,sq); acc <= gfmul(acc,sq_n); sq <= sq_n; cnt <= cnt-1;
//   - on the step where cnt==1, load y<=gfmul(acc,sq_n) and div_by_zero<=dz, go to DONE.
//  Latency:
//   - accept edge t -> out_valid high after edge t+M-1 (M-1 CALC cycles);
//   - M=8 gives 7 cycles.
//  DONE:
//   - y and div_by_zero are held stable while out_valid=1 && out_ready=0;
//   - out_ready at an edge -> IDLE; out_valid drops the next cycle.
//  Throughput:
//   - no new accept while CALC or DONE;
//   - minimum issue interval is M+1 cycles (1 accept + M-1 CALC + 1 DONE).
//  a==0: y=0 falls out of the arithmetic; no special case; div_by_zero=0 if b!=0.
//  b==0:
//   - y=0 (b^k=0) and div_by_zero=1;
//   - latency is unchanged; no early exit.
//  a==0 && b==0: y=0, div_by_zero=1.
//  out_ready asserted while not DONE: ignored. in_valid while not IDLE: ignored, not queued.
//  a/b may change freely after the accept edge; internal copies are used.
//  Iteration counter is $clog2(M) bits wide; it never wraps within an operation.
// TESTING
//  All cases below use M=8, POLY=9'h11D unless stated.
//  1. Identity: a=0x02, b=0x02 -> y=0x01, div_by_zero=0, out_valid 7 cycles after accept.
//  2. Inverse: a=0x01, b=0x02 -> y=0x8E. Unit divisor: a=0x03, b=0x01 -> y=0x03.
//  3. Zero cases:
//     - a=0x00, b=0x05 -> y=0x00, div_by_zero=0;
//     - a=0x57, b=0x00 -> y=0x00, div_by_zero=1, same latency.
//  4. Backpressure and issue interval:
//     - out_ready held 0 for 10 cycles -> y and flag stable, in_ready=0 throughout;
//     - release -> IDLE next cycle;
//     - back-to-back in_valid -> accepts spaced >= 9 cycles.
//  5. Reset mid-CALC:
//     - assert rst 3 cycles after accept -> out_valid=0, y=0, in_ready=1 immediately;
//     - no stale result appears after release.
//  6. Exhaustive vs golden model:
//     - all 65536 (a,b) pairs at M=8 checked against a log/exp table model;
//     - repeat with M=4, POLY=5'h13; check 0x1/0x2 -> 0x9.

Source files
------------

// File: rtl/gf_div_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^M) divider.
// The master side issues operand pairs and consumes quotients.
interface gf_div_seq_if #(
  parameter int unsigned M = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] y;
  logic         div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, div_by_zero
  );
endinterface

// File: rtl/gf_div_seq.sv
// Handshaked multi-cycle GF(2^M) divider: y = a * b^(2^M-2), computed by
// square-and-multiply one step per clock, result held until accepted.
module gf_div_seq #(
  parameter int unsigned M    = 8,
  parameter logic [M:0]  POLY = 9'h11D
) (
  input  logic        clk,
  input  logic        rst,
  gf_div_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [M-1:0]   acc;
  logic [M-1:0]   sq;
  logic [CNT_W-1:0] cnt;
  logic           dz;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [M-1:0]   y_r;
  logic           dbz_r;

  logic [M-1:0]   sq_n;
  logic [M-1:0]   prod;

  // Carry-less shift-and-add multiply, reducing by POLY after every shift.
  function automatic logic [M-1:0] gfmul(input logic [M-1:0] x, input logic [M-1:0] z);
    logic [M-1:0] p;
    logic [M-1:0] xs;
    p  = '0;
    xs = x;
    for (int i = 0; i < int'(M); i++) begin
      if (z[i]) p = p ^ xs;
      xs = {xs[M-2:0], 1'b0} ^ (xs[M-1] ? POLY[M-1:0] : '0);
    end
    return p;
  endfunction

  assign sq_n = gfmul(sq, sq);
  assign prod = gfmul(acc, sq_n);

  // acc accumulates a * b^2 * b^4 * ... * b^(2^(M-1)) = a * b^(2^M-2) over M-1 steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      sq          <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc        <= bus.a;
            sq         <= bus.b;
            dz         <= (bus.b == '0);
            cnt        <= CNT_W'(M - 1);
            in_ready_r <= 1'b0;
            state      <= CALC;
          end
        end
        CALC: begin
          acc <= prod;
          sq  <= sq_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            y_r         <= prod;
            dbz_r       <= dz;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.y           = y_r;
  assign bus.div_by_zero = dbz_r;

endmodule
